// File: rtl/cdr_gear_ctrl.sv
// CDR acquisition/tracking sequencer: windows |f_n|, switches loop-filter gains
// between acquire and track, declares lock and clears the loop filter on restart.
module cdr_gear_ctrl #(
  parameter int ERR_W       = 16,
  parameter int WIN_LOG2    = 6,
  parameter int LOCK_THR    = 512,
  parameter int UNLOCK_THR  = 2048,
  parameter int LOCK_WINS   = 4,
  parameter int UNLOCK_WINS = 2,
  parameter int TMO_WINS    = 64,
  parameter int ACQ_KP      = 4,
  parameter int ACQ_KI      = 10,
  parameter int TRK_KP      = 6,
  parameter int TRK_KI      = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sample_en,
  input  logic signed [ERR_W-1:0]   f_n,
  input  logic                      relock_req,
  output logic [4:0]                kp_shift,
  output logic [4:0]                ki_shift,
  output logic                      lf_clear,
  output logic                      locked,
  output logic [1:0]                state,
  output logic [ERR_W+WIN_LOG2-1:0] err_metric
);

  localparam int ACC_W = ERR_W + WIN_LOG2;
  localparam int GW    = $clog2(LOCK_WINS + 1);
  localparam int BW    = $clog2(UNLOCK_WINS + 1);
  localparam int TW    = $clog2(TMO_WINS + 1);

  localparam logic [4:0] ACQ_KP_L = 5'(ACQ_KP);
  localparam logic [4:0] ACQ_KI_L = 5'(ACQ_KI);
  localparam logic [4:0] TRK_KP_L = 5'(TRK_KP);
  localparam logic [4:0] TRK_KI_L = 5'(TRK_KI);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    ACQ   = 2'b10,
    TRACK = 2'b11
  } state_t;

  // Magnitude without saturation: the most negative code maps to 2^(ERR_W-1).
  function automatic logic [ERR_W-1:0] abs_err(input logic signed [ERR_W-1:0] x);
    logic signed [ERR_W-1:0] neg;
    neg = -x;
    return x[ERR_W-1] ? $unsigned(neg) : $unsigned(x);
  endfunction

  state_t                state_p0, state_nxt;
  logic [ACC_W-1:0]      acc_p0, acc_nxt;
  logic [WIN_LOG2-1:0]   win_p0, win_nxt;
  logic [GW-1:0]         good_p0, good_nxt;
  logic [BW-1:0]         bad_p0, bad_nxt;
  logic [TW-1:0]         tmo_p0, tmo_nxt;
  logic [ACC_W-1:0]      metric_nxt;
  logic [ACC_W-1:0]      sum;
  logic                  win_close, good_win, bad_win;

  always_comb begin
    state_nxt  = state_p0;
    acc_nxt    = acc_p0;
    win_nxt    = win_p0;
    good_nxt   = good_p0;
    bad_nxt    = bad_p0;
    tmo_nxt    = tmo_p0;
    metric_nxt = err_metric;
    sum        = acc_p0 + ACC_W'(abs_err(f_n));
    win_close  = (win_p0 == '1);
    good_win   = (sum < ACC_W'(LOCK_THR));
    bad_win    = (sum > ACC_W'(UNLOCK_THR));

    if (!en) begin
      // Disable drops any partial window; the last completed metric is kept.
      state_nxt = IDLE;
      acc_nxt   = '0;
      win_nxt   = '0;
      good_nxt  = '0;
      bad_nxt   = '0;
      tmo_nxt   = '0;
    end else begin
      case (state_p0)
        IDLE: begin
          state_nxt = CLEAR;
        end
        CLEAR: begin
          state_nxt = ACQ;
          acc_nxt   = '0;
          win_nxt   = '0;
          good_nxt  = '0;
          bad_nxt   = '0;
          tmo_nxt   = '0;
        end
        ACQ, TRACK: begin
          if (relock_req) begin
            state_nxt = CLEAR;
          end else if (sample_en) begin
            acc_nxt = sum;
            win_nxt = win_p0 + 1'b1;
            if (win_close) begin
              acc_nxt    = '0;
              metric_nxt = sum;
              if (state_p0 == ACQ) begin
                good_nxt = good_win ? good_p0 + 1'b1 : '0;
                tmo_nxt  = tmo_p0 + 1'b1;
                if (good_nxt == GW'(LOCK_WINS)) begin
                  state_nxt = TRACK;
                  good_nxt  = '0;
                  tmo_nxt   = '0;
                  bad_nxt   = '0;
                end else if (tmo_nxt == TW'(TMO_WINS)) begin
                  state_nxt = CLEAR;
                end
              end else begin
                bad_nxt = bad_win ? bad_p0 + 1'b1 : '0;
                if (bad_nxt == BW'(UNLOCK_WINS)) begin
                  state_nxt = CLEAR;
                end
              end
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State/counter register stage; outputs decode the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= IDLE;
      acc_p0     <= '0;
      win_p0     <= '0;
      good_p0    <= '0;
      bad_p0     <= '0;
      tmo_p0     <= '0;
      err_metric <= '0;
      kp_shift   <= ACQ_KP_L;
      ki_shift   <= ACQ_KI_L;
      lf_clear   <= 1'b1;
      locked     <= 1'b0;
    end else begin
      state_p0   <= state_nxt;
      acc_p0     <= acc_nxt;
      win_p0     <= win_nxt;
      good_p0    <= good_nxt;
      bad_p0     <= bad_nxt;
      tmo_p0     <= tmo_nxt;
      err_metric <= metric_nxt;
      kp_shift   <= (state_nxt == TRACK) ? TRK_KP_L : ACQ_KP_L;
      ki_shift   <= (state_nxt == TRACK) ? TRK_KI_L : ACQ_KI_L;
      lf_clear   <= (state_nxt == IDLE) || (state_nxt == CLEAR);
      locked     <= (state_nxt == TRACK);
    end
  end

  assign state = state_p0;

endmodule
